// File: rtl/demux_1to8_gen.sv
// rtl/demux_1to8_gen.sv - registered 1-to-8 demultiplexer built from eight generated lanes
//
// Routes data input i to the output lane chosen by sel and drives every
// other lane to 0. All lanes are registered, so latency is one clock.
//
// Optional build macro: DEMUX_STATUS_EN adds the registered status outputs
// sel_q and hit.
//
// Ports:
//   clk    in   1           rising-edge clock
//   reset  in   1           synchronous, active-low reset
//   i      in   DATA_W      data to route
//   sel    in   3           lane select, 0..7
//   out    out  8*DATA_W    lane k at bits [k*DATA_W +: DATA_W]
//   sel_q  out  3           (DEMUX_STATUS_EN) registered sel
//   hit    out  1           (DEMUX_STATUS_EN) registered OR of the selected lane's next value

module demux_1to8_gen #(
  parameter int DATA_W = 1,
  parameter int N_OUT  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       i,
  input  logic [2:0]              sel,
`ifdef DEMUX_STATUS_EN
  output logic [2:0]              sel_q,
  output logic [0:0]              hit,
`endif
  output logic [N_OUT*DATA_W-1:0] out
);

  for (genvar k = 0; k < N_OUT; k++) begin : g_lane
    localparam logic [2:0] LANE_SEL = 3'(k);

    logic [DATA_W-1:0] lane_d;
    logic [DATA_W-1:0] lane_q;

    always_comb begin
      lane_d = '0;
      if (sel == LANE_SEL) begin
        lane_d = i;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        lane_q <= '0;
      end else begin
        lane_q <= lane_d;
      end
    end

    assign out[k*DATA_W +: DATA_W] = lane_q;
  end

`ifdef DEMUX_STATUS_EN
  logic [2:0] sel_q_d;
  logic [0:0] hit_d;
  logic [2:0] sel_q_q;
  logic [0:0] hit_q;

  // Every sel code selects a lane, and the selected lane's next value is
  // always i, so the OR-reduction of that lane reduces to |i.
  always_comb begin
    sel_q_d = sel;
    hit_d   = |i;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_q_q <= '0;
      hit_q   <= '0;
    end else begin
      sel_q_q <= sel_q_d;
      hit_q   <= hit_d;
    end
  end

  assign sel_q = sel_q_q;
  assign hit   = hit_q;
`endif

endmodule

// File: tb/tb_demux_1to8_gen.sv
// tb/tb_demux_1to8_gen.sv - self-checking bench for demux_1to8_gen

module tb_demux_1to8_gen;

  logic       clk;
  logic       reset;
  logic [0:0] i;
  logic [2:0] sel;
  logic [7:0] out;
`ifdef DEMUX_STATUS_EN
  logic [2:0] sel_q;
  logic [0:0] hit;
`endif

  int checks;
  int errors;

  demux_1to8_gen #(
    .DATA_W(1),
    .N_OUT (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .i    (i),
    .sel  (sel),
`ifdef DEMUX_STATUS_EN
    .sel_q(sel_q),
    .hit  (hit),
`endif
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       d;
    logic [2:0] s;
    logic [7:0] exp_out;
    logic [2:0] exp_selq;
    logic       exp_hit;
  } vec_t;

  vec_t tbl[$];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Drive at the falling edge, let the rising edge sample, look 1 time unit later.
  task automatic step(input logic r, input logic d, input logic [2:0] s);
    @(negedge clk);
    reset = r;
    i     = d;
    sel   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic d, input logic [2:0] s, input logic [7:0] e);
    vec_t v;
    v.rst      = r;
    v.d        = d;
    v.s        = s;
    v.exp_out  = e;
    v.exp_selq = r ? s : 3'd0;
    v.exp_hit  = r ? d : 1'b0;
    tbl.push_back(v);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    i      = 1'b0;
    sel    = 3'd0;

    // reset held two edges, then release
    add(1'b0, 1'b1, 3'd5, 8'h00);
    add(1'b0, 1'b1, 3'd5, 8'h00);
    add(1'b1, 1'b1, 3'd5, 8'h20);
    // sweep
    add(1'b1, 1'b1, 3'd0, 8'h01);
    add(1'b1, 1'b1, 3'd1, 8'h02);
    add(1'b1, 1'b1, 3'd2, 8'h04);
    add(1'b1, 1'b1, 3'd3, 8'h08);
    add(1'b1, 1'b1, 3'd4, 8'h10);
    add(1'b1, 1'b1, 3'd5, 8'h20);
    add(1'b1, 1'b1, 3'd6, 8'h40);
    add(1'b1, 1'b1, 3'd7, 8'h80);
    // wrap 7 -> 0
    add(1'b1, 1'b1, 3'd0, 8'h01);
    // data zero
    add(1'b1, 1'b0, 3'd3, 8'h00);
    // toggling i at sel 6
    add(1'b1, 1'b1, 3'd6, 8'h40);
    add(1'b1, 1'b0, 3'd6, 8'h00);
    add(1'b1, 1'b1, 3'd6, 8'h40);
    // reset mid-run
    add(1'b1, 1'b1, 3'd2, 8'h04);
    add(1'b0, 1'b1, 3'd2, 8'h00);
    add(1'b1, 1'b1, 3'd2, 8'h04);

    for (int n = 0; n < tbl.size(); n++) begin
      step(tbl[n].rst, tbl[n].d, tbl[n].s);
      check8($sformatf("vec%0d_out", n), out, tbl[n].exp_out);
      checks++;
      if ($countones(out) > 1) begin
        errors++;
        $display("FAIL vec%0d_onehot: got %h expected at most one bit set", n, out);
      end
`ifdef DEMUX_STATUS_EN
      check8($sformatf("vec%0d_sel_q", n), {5'd0, sel_q}, {5'd0, tbl[n].exp_selq});
      check8($sformatf("vec%0d_hit", n), {7'd0, hit}, {7'd0, tbl[n].exp_hit});
`endif
    end

    // Reset held several edges with i and sel moving: out must stay 0.
    for (int n = 0; n < 4; n++) begin
      step(1'b0, 1'b1, 3'(n * 3 + 1));
      check8($sformatf("rst_hold%0d", n), out, 8'h00);
    end

    // Simultaneous sel/i changes; out must also hold steady between edges.
    begin
      logic [2:0] s_seq [6];
      logic       d_seq [6];
      logic [7:0] exp;
      s_seq = '{3'd4, 3'd1, 3'd1, 3'd7, 3'd3, 3'd0};
      d_seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int n = 0; n < 6; n++) begin
        step(1'b1, d_seq[n], s_seq[n]);
        exp = d_seq[n] ? (8'h01 << s_seq[n]) : 8'h00;
        check8($sformatf("simul%0d_edge", n), out, exp);
        @(negedge clk);
        check8($sformatf("simul%0d_mid", n), out, exp);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_1to8_gen.md
# demux_1to8_gen

Registered 1-to-8 demultiplexer built from a generate loop of eight identical output lanes. It routes one data input to the output lane selected by a 3-bit select and drives every other lane to 0. The block sits in the week-1 RTL/synthesis set as a small datapath primitive between a select source (counter or FSM) and eight downstream consumers.

## Interface
Parameters:
- DATA_W, default 1: width of the data input and of each output lane.
- N_OUT, default 8: number of lanes. Fixed at 8; the select width is log2(N_OUT) = 3.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- i  input  DATA_W  data to route.
- sel  input  3  lane select, binary, 0..7.
- out  output  8*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].

## Operation
- One generate loop instantiates lanes k = 0..7.
- Each lane has its own decode compare (sel == k) and its own output register.
- On each rising edge of clk with reset high:
  - lane k <= i when sel == k;
  - otherwise lane k <= 0.
- Exactly one lane can carry i at a time. When i == 0, all lanes read 0.
- No enable input: every edge updates all lanes.
- sel is unsigned. All 8 codes are valid, so no out-of-range case exists.
- X on sel: lanes may take X in simulation. Benches must not drive X after reset.
- The synthesizable core contains no latches and no combinational path from inputs to out.

## Timing
- Latency: 1 clock. out reflects the i and sel values sampled at the previous rising edge.
- Reset:
  - reset low at a rising edge sets out = 0 (all lanes) on that edge.
  - out stays 0 on every edge while reset is low, regardless of i and sel.
- Reset release: the first edge with reset high loads the decoded value.
- Reset mid-operation: the selected lane clears on the next edge. No other state exists.
- Simultaneous sel and i change: both are sampled on the same edge. No glitch reaches out, because all lanes are registered.
- sel wrap 7 -> 0: lane 7 clears and lane 0 loads i on the same edge.

## Configuration
- DEMUX_STATUS_EN defined adds two registered outputs, both updated on the same edge as out:
  - sel_q [2:0]: registered sel.
  - hit [0:0]: registered OR-reduction of the next-state value of the selected lane.
  - Both reset to 0 when reset is low.
- DEMUX_STATUS_EN undefined: these ports do not exist and the block is exactly as described above.

## Test plan
- Reset: hold reset=0 for 2 edges with i=1, sel=5 -> out=8'h00 after each edge; release -> next edge out=8'h20.
- Sweep: i=1, sel=0..7, one value per edge -> out=8'h01,02,04,08,10,20,40,80, each 1 cycle after its sel.
- Data zero: i=0, sel=3 -> out=8'h00.
- Toggling i at fixed sel=6: i=1,0,1 over 3 edges -> out=8'h40,00,40.
- Wrap: sel=7 then 0 with i=1 -> out=8'h80 then 8'h01, never two bits set.
- Reset mid-run: sel=2, i=1 gives out=8'h04; drive reset=0 for one edge -> out=8'h00; release -> 8'h04. With DEMUX_STATUS_EN defined, sel_q=0 and hit=0 during reset; afterwards sel_q=2 and hit=1.
